// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register and writeback stage: captures the MEM result bundle,
// selects the register-file write value and latches halt. Optional retire counter via RETIRE_CNT_EN.
module memwb_writeback
`ifdef RETIRE_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] EXMEM_Instr,
  input  logic [31:0] EXMEM_Ctrl,
  input  logic        EXMEM_Valid,
  input  logic [15:0] EXMEM_AluOut,
  input  logic [15:0] EXMEM_MemData,
  input  logic [15:0] EXMEM_PcPlusTwo,
  input  logic        EXMEM_Flag,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] MEMWB_Instr,
  output logic        MEMWB_RegWriteEN,
  output logic [1:0]  MEMWB_RegDst,
  output logic [2:0]  writeregsel,
  output logic [15:0] writedata,
  output logic        MEMWB_Valid,
  output logic        halt
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  localparam logic [2:0] SRC_ALU  = 3'b000;
  localparam logic [2:0] SRC_MEM  = 3'b001;
  localparam logic [2:0] SRC_PC   = 3'b010;
  localparam logic [2:0] SRC_FLAG = 3'b011;

  logic [15:0] instr_q;
  logic [15:0] alu_q;
  logic [15:0] mem_q;
  logic [15:0] pc_q;
  logic [1:0]  regdst_q;
  logic [2:0]  src_q;
  logic [2:0]  dst_q;
  logic        we_q;
  logic        dump_q;
  logic        valid_q;
  logic        flag_q;
  logic        halt_q;

  // Ctrl bits not consumed by writeback; dst_q is kept for the decode-side cross-check only.
  logic unused_bits;
  assign unused_bits = ^{EXMEM_Ctrl[31:29], EXMEM_Ctrl[24:12], EXMEM_Ctrl[10:5], dst_q};

  // Pipeline register: once halted the stage freezes until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      pc_q     <= '0;
      regdst_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
      dump_q   <= 1'b0;
      valid_q  <= 1'b0;
      flag_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else if (!halt_q) begin
      halt_q <= dump_q & valid_q;
      if (flush) begin
        instr_q  <= '0;
        alu_q    <= '0;
        mem_q    <= '0;
        pc_q     <= '0;
        regdst_q <= '0;
        src_q    <= '0;
        dst_q    <= '0;
        we_q     <= 1'b0;
        dump_q   <= 1'b0;
        valid_q  <= 1'b0;
        flag_q   <= 1'b0;
      end else if (!stall) begin
        instr_q  <= EXMEM_Instr;
        alu_q    <= EXMEM_AluOut;
        mem_q    <= EXMEM_MemData;
        pc_q     <= EXMEM_PcPlusTwo;
        regdst_q <= EXMEM_Ctrl[1:0];
        src_q    <= EXMEM_Ctrl[4:2];
        dst_q    <= EXMEM_Ctrl[28:26];
        we_q     <= EXMEM_Ctrl[11];
        dump_q   <= EXMEM_Ctrl[25];
        valid_q  <= EXMEM_Valid;
        flag_q   <= EXMEM_Flag;
      end
    end
  end

  assign MEMWB_Instr      = instr_q;
  assign MEMWB_RegDst     = regdst_q;
  assign MEMWB_Valid      = valid_q;
  assign halt             = halt_q;
  assign MEMWB_RegWriteEN = we_q & valid_q & ~halt_q;

  // Destination register field chosen by RegDst; 11 is the link register.
  always_comb begin
    writeregsel = 3'b000;
    case (regdst_q)
      2'b00:   writeregsel = instr_q[4:2];
      2'b01:   writeregsel = instr_q[7:5];
      2'b10:   writeregsel = instr_q[10:8];
      default: writeregsel = 3'b111;
    endcase
  end

  always_comb begin
    writedata = 16'h0000;
    case (src_q)
      SRC_ALU:  writedata = alu_q;
      SRC_MEM:  writedata = mem_q;
      SRC_PC:   writedata = pc_q;
      SRC_FLAG: writedata = {15'b0, flag_q};
      default:  writedata = 16'h0000;
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_q;

  // Counts each instruction as it leaves WB, written or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (valid_q && !stall && !halt_q) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_memwb_writeback.sv
// Scoreboard bench for memwb_writeback: stimulus pushes expected WB results,
// a negedge monitor pops and compares whenever a valid, non-halted result is presented.
module tb_memwb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] EXMEM_Instr;
  logic [31:0] EXMEM_Ctrl;
  logic        EXMEM_Valid;
  logic [15:0] EXMEM_AluOut;
  logic [15:0] EXMEM_MemData;
  logic [15:0] EXMEM_PcPlusTwo;
  logic        EXMEM_Flag;
  logic        stall;
  logic        flush;
  logic [15:0] MEMWB_Instr;
  logic        MEMWB_RegWriteEN;
  logic [1:0]  MEMWB_RegDst;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        MEMWB_Valid;
  logic        halt;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];

  memwb_writeback dut (
    .clk(clk), .rst(rst),
    .EXMEM_Instr(EXMEM_Instr), .EXMEM_Ctrl(EXMEM_Ctrl), .EXMEM_Valid(EXMEM_Valid),
    .EXMEM_AluOut(EXMEM_AluOut), .EXMEM_MemData(EXMEM_MemData),
    .EXMEM_PcPlusTwo(EXMEM_PcPlusTwo), .EXMEM_Flag(EXMEM_Flag),
    .stall(stall), .flush(flush),
    .MEMWB_Instr(MEMWB_Instr), .MEMWB_RegWriteEN(MEMWB_RegWriteEN),
    .MEMWB_RegDst(MEMWB_RegDst), .writeregsel(writeregsel), .writedata(writedata),
    .MEMWB_Valid(MEMWB_Valid), .halt(halt)
`ifdef RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] instr, input logic [1:0] rd, input logic [2:0] src,
                      input logic we, input logic dump, input logic [2:0] dst,
                      input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc,
                      input logic flg, input logic vld);
    rst             = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    EXMEM_Instr     = instr;
    EXMEM_Ctrl      = '0;
    EXMEM_Ctrl[1:0] = rd;
    EXMEM_Ctrl[4:2] = src;
    EXMEM_Ctrl[11]  = we;
    EXMEM_Ctrl[25]  = dump;
    EXMEM_Ctrl[28:26] = dst;
    EXMEM_AluOut    = alu;
    EXMEM_MemData   = mem;
    EXMEM_PcPlusTwo = pc;
    EXMEM_Flag      = flg;
    EXMEM_Valid     = vld;
  endtask

  task automatic expect_wb(input logic [15:0] instr, input logic we, input logic [2:0] wsel,
                           input logic [15:0] wdata);
    exp_t e;
    e.instr = instr;
    e.we    = we;
    e.wsel  = wsel;
    e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per cycle that WB presents a live result.
  always @(negedge clk) begin
    if (rst === 1'b0 && MEMWB_Valid === 1'b1 && halt === 1'b0) begin
      assert (dut.dst_q == writeregsel)
        else $error("Dst_Reg %0d disagrees with writeregsel %0d", dut.dst_q, writeregsel);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h with no pending expectation", MEMWB_Instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_instr", 32'(MEMWB_Instr), 32'(e.instr));
        chk("wb_we",    32'(MEMWB_RegWriteEN), 32'(e.we));
        chk("wb_wsel",  32'(writeregsel), 32'(e.wsel));
        chk("wb_wdata", 32'(writedata), 32'(e.wdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    EXMEM_Instr = '0; EXMEM_Ctrl = '0; EXMEM_Valid = 1'b0; EXMEM_AluOut = '0;
    EXMEM_MemData = '0; EXMEM_PcPlusTwo = '0; EXMEM_Flag = 1'b0;

    // Reset with garbage upstream
    for (int i = 0; i < 2; i++) begin
      EXMEM_Instr = 16'($urandom); EXMEM_Ctrl = $urandom; EXMEM_Valid = 1'b1;
      EXMEM_AluOut = 16'($urandom); EXMEM_MemData = 16'($urandom);
      EXMEM_PcPlusTwo = 16'($urandom); EXMEM_Flag = 1'b1;
      step();
      chk("rst_instr", 32'(MEMWB_Instr), 32'h0);
      chk("rst_valid", 32'(MEMWB_Valid), 32'h0);
      chk("rst_we",    32'(MEMWB_RegWriteEN), 32'h0);
      chk("rst_rd",    32'(MEMWB_RegDst), 32'h0);
      chk("rst_wsel",  32'(writeregsel), 32'h0);
      chk("rst_wdata", 32'(writedata), 32'h0);
      chk("rst_halt",  32'(halt), 32'h0);
`ifdef RETIRE_CNT_EN
      chk("rst_cnt",   retire_cnt, 32'h0);
`endif
    end

    // ADD -> r5 from ALU
    expect_wb(16'h0014, 1'b1, 3'd5, 16'h1234);
    send(16'h0014, 2'b00, 3'b000, 1'b1, 1'b0, 3'd5, 16'h1234, 16'h5678, 16'h0002, 1'b0, 1'b1);
    step();
    // Load -> r2 from memory
    expect_wb(16'h8040, 1'b1, 3'd2, 16'hBEEF);
    send(16'h8040, 2'b01, 3'b001, 1'b1, 1'b0, 3'd2, 16'h1111, 16'hBEEF, 16'h0004, 1'b0, 1'b1);
    step();
    // JAL -> r7 link
    expect_wb(16'h3000, 1'b1, 3'd7, 16'h0042);
    send(16'h3000, 2'b11, 3'b010, 1'b1, 1'b0, 3'd7, 16'h2222, 16'h3333, 16'h0042, 1'b0, 1'b1);
    step();
    // SLT -> r3 flag
    expect_wb(16'hE300, 1'b1, 3'd3, 16'h0001);
    send(16'hE300, 2'b10, 3'b011, 1'b1, 1'b0, 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step();
    // Non-writing, source 1xx gives zero
    expect_wb(16'h001C, 1'b0, 3'd7, 16'h0000);
    send(16'h001C, 2'b00, 3'b100, 1'b0, 1'b0, 3'd7, 16'h5555, 16'h6666, 16'h7777, 1'b1, 1'b1);
    step();
    // Load AAAA then stall three cycles with changing ALU input
    expect_wb(16'h0008, 1'b1, 3'd2, 16'hAAAA);
    send(16'h0008, 2'b00, 3'b000, 1'b1, 1'b0, 3'd2, 16'hAAAA, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      expect_wb(16'h0008, 1'b1, 3'd2, 16'hAAAA);
      send(16'h0010, 2'b00, 3'b000, 1'b1, 1'b0, 3'd4, 16'h0101 * 16'(i + 1), 16'h0, 16'h0, 1'b0, 1'b1);
      stall = 1'b1;
      step();
    end
    // Stall and flush together: flush wins
    send(16'h0010, 2'b00, 3'b000, 1'b1, 1'b0, 3'd4, 16'h4444, 16'h0, 16'h0, 1'b0, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(MEMWB_Valid), 32'h0);
    chk("flush_we",    32'(MEMWB_RegWriteEN), 32'h0);
    // Bubble with RegWriteEn set never writes
    send(16'h0010, 2'b00, 3'b000, 1'b1, 1'b0, 3'd4, 16'h4444, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("bubble_valid", 32'(MEMWB_Valid), 32'h0);
    chk("bubble_we",    32'(MEMWB_RegWriteEN), 32'h0);

`ifdef RETIRE_CNT_EN
    rst = 1'b1;
    step();
    chk("cnt_rst", retire_cnt, 32'h0);
    for (int i = 0; i < 10; i++) begin
      expect_wb(16'(i % 8) << 2, 1'b1, 3'(i % 8), 16'h0100 + 16'(i));
      send(16'(i % 8) << 2, 2'b00, 3'b000, 1'b1, 1'b0, 3'(i % 8), 16'h0100 + 16'(i),
           16'h0, 16'h0, 1'b0, 1'b1);
      step();
      if (i == 3 || i == 6) begin
        expect_wb(16'(i % 8) << 2, 1'b1, 3'(i % 8), 16'h0100 + 16'(i));
        stall = 1'b1;
        step();
      end
      if (i == 1 || i == 4 || i == 8) begin
        send(16'h0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
      end
    end
    send(16'h0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("cnt_ten", retire_cnt, 32'd10);
    expect_wb(16'h0004, 1'b1, 3'd1, 16'h0099);
    send(16'h0004, 2'b00, 3'b000, 1'b1, 1'b0, 3'd1, 16'h0099, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    force dut.retire_q = '1;
    #1;
    release dut.retire_q;
    chk("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
    send(16'h0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("cnt_wrap", retire_cnt, 32'h0);
`endif

    // Halt: sets one cycle after HALT reaches WB, then freezes the stage
    rst = 1'b1;
    step();
    expect_wb(16'h0000, 1'b0, 3'd0, 16'h0000);
    send(16'h0000, 2'b00, 3'b100, 1'b0, 1'b1, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    chk("halt_early", 32'(halt), 32'h0);
    send(16'h0014, 2'b00, 3'b000, 1'b1, 1'b0, 3'd5, 16'h7777, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    chk("halt_set",   32'(halt), 32'h1);
    chk("halt_we",    32'(MEMWB_RegWriteEN), 32'h0);
    chk("halt_instr", 32'(MEMWB_Instr), 32'h0014);
    for (int i = 0; i < 3; i++) begin
      send(16'h0040, 2'b01, 3'b001, 1'b1, 1'b0, 3'd2, 16'h0, 16'h9999, 16'h0, 1'b0, 1'b1);
      flush = (i == 1);
      stall = (i == 2);
      step();
      chk("halt_sticky", 32'(halt), 32'h1);
      chk("halt_freeze", 32'(MEMWB_Instr), 32'h0014);
      chk("halt_nowr",   32'(MEMWB_RegWriteEN), 32'h0);
    end
    rst = 1'b1;
    step();
    chk("halt_clear",  32'(halt), 32'h0);
    chk("halt_rst_v",  32'(MEMWB_Valid), 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
